// File: rtl/nrzi_tx_serializer.sv
// rtl/nrzi_tx_serializer.sv - parallel-to-serial NRZI line transmitter (1 toggles, 0 holds, idle level 1)
// Zero-run bit stuffing is compiled in only when NRZI_BIT_STUFF_EN is defined.
module nrzi_tx_serializer #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int STUFF_LIMIT  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              line_out,
  output logic              stuff_pulse,
  output logic              busy
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef NRZI_BIT_STUFF_EN
    , STUFF
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              line_q, line_d;
  logic              ready_q, ready_d;

  logic              period_end;
  logic              more_bits;
  logic [IDX_W-1:0]  idx_next;
  logic              next_bit;

`ifdef NRZI_BIT_STUFF_EN
  localparam int RUN_W = $clog2(STUFF_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(STUFF_LIMIT);

  logic [RUN_W-1:0]  run_q, run_d;
  logic [RUN_W-1:0]  run_inc;
  logic              pulse_q, pulse_d;

  assign run_inc = (run_q == RUN_LIMIT) ? run_q : run_q + 1'b1;
`endif

  assign period_end = (div_q == LAST_DIV);
  assign more_bits  = (idx_q != LAST_IDX);
  assign idx_next   = idx_q + 1'b1;
  assign next_bit   = shift_q[idx_next];

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    div_d   = div_q;
    line_d  = line_q;
    ready_d = ready_q;
`ifdef NRZI_BIT_STUFF_EN
    run_d   = run_q;
    pulse_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Bit 0 goes onto the line on the accept edge itself.
        if (tx_valid) begin
          shift_d = tx_data;
          line_d  = line_q ^ tx_data[0];
          div_d   = '0;
          idx_d   = '0;
          state_d = SHIFT;
          ready_d = 1'b0;
`ifdef NRZI_BIT_STUFF_EN
          run_d   = tx_data[0] ? '0 : RUN_W'(1);
`endif
        end
      end
      SHIFT: begin
        div_d = period_end ? '0 : div_q + 1'b1;
        if (period_end) begin
`ifdef NRZI_BIT_STUFF_EN
          if (run_q == RUN_LIMIT) begin
            state_d = STUFF;
            line_d  = ~line_q;
            run_d   = '0;
            pulse_d = 1'b1;
          end else
`endif
          if (more_bits) begin
            idx_d  = idx_next;
            line_d = line_q ^ next_bit;
`ifdef NRZI_BIT_STUFF_EN
            run_d  = next_bit ? '0 : run_inc;
`endif
          end else begin
            state_d = IDLE;
            ready_d = 1'b1;
          end
        end
      end
`ifdef NRZI_BIT_STUFF_EN
      STUFF: begin
        // A stuff bit never consumes data; the index still points at the last bit sent.
        div_d = period_end ? '0 : div_q + 1'b1;
        if (period_end) begin
          if (more_bits) begin
            state_d = SHIFT;
            idx_d   = idx_next;
            line_d  = line_q ^ next_bit;
            run_d   = next_bit ? '0 : run_inc;
          end else begin
            state_d = IDLE;
            ready_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      div_q   <= '0;
      line_q  <= 1'b1;
      ready_q <= 1'b1;
`ifdef NRZI_BIT_STUFF_EN
      run_q   <= '0;
      pulse_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      line_q  <= line_d;
      ready_q <= ready_d;
`ifdef NRZI_BIT_STUFF_EN
      run_q   <= run_d;
      pulse_q <= pulse_d;
`endif
    end
  end

  assign tx_ready = ready_q;
  assign busy     = ~ready_q;
  assign line_out = line_q;
`ifdef NRZI_BIT_STUFF_EN
  assign stuff_pulse = pulse_q;
`else
  assign stuff_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_nrzi_tx_serializer.sv
// tb/tb_nrzi_tx_serializer.sv - randomized and directed bench for nrzi_tx_serializer (CLKS_PER_BIT 1 and 4)
// Stuffing expectations follow NRZI_BIT_STUFF_EN.
module tb_nrzi_tx_serializer;

`ifdef NRZI_BIT_STUFF_EN
  localparam bit STUFF_ON = 1'b1;
`else
  localparam bit STUFF_ON = 1'b0;
`endif
  localparam int LIMIT = 6;

  typedef struct {
    int          len;
    logic [63:0] ln;
    logic [63:0] pl;
  } wave_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data1 = 8'h00, tx_data4 = 8'h00;
  logic       tx_valid1 = 1'b0, tx_valid4 = 1'b0;
  logic       ready1, line1, pulse1, busy1;
  logic       ready4, line4, pulse4, busy4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nrzi_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(1), .STUFF_LIMIT(LIMIT)) dut1 (
    .clk(clk), .rst(rst_n), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(ready1), .line_out(line1), .stuff_pulse(pulse1), .busy(busy1));

  nrzi_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(4), .STUFF_LIMIT(LIMIT)) dut4 (
    .clk(clk), .rst(rst_n), .tx_data(tx_data4), .tx_valid(tx_valid4),
    .tx_ready(ready4), .line_out(line4), .stuff_pulse(pulse4), .busy(busy4));

  // Whole-word waveform: one entry per clock cycle after the accept edge.
  function automatic wave_t build(input logic [7:0] d, input int cpb, input logic start);
    wave_t w;
    logic  lvl;
    int    run;
    w.len = 0; w.ln = '0; w.pl = '0;
    lvl = start; run = 0;
    for (int i = 0; i < 8; i++) begin
      if (d[i]) begin lvl = ~lvl; run = 0; end
      else run = run + 1;
      for (int c = 0; c < cpb; c++) begin
        w.ln[w.len] = lvl; w.pl[w.len] = 1'b0; w.len++;
      end
      if (STUFF_ON && run == LIMIT) begin
        lvl = ~lvl; run = 0;
        for (int c = 0; c < cpb; c++) begin
          w.ln[w.len] = lvl; w.pl[w.len] = (c == 0); w.len++;
        end
      end
    end
    return w;
  endfunction

  logic  m1_line, m1_ready, m1_pulse, m4_line, m4_ready, m4_pulse;
  wave_t w1, w4;
  int    pos1, pos4;

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m1_line = 1'b1; m1_ready = 1'b1; m1_pulse = 1'b0; w1.len = 0; pos1 = 0;
      m4_line = 1'b1; m4_ready = 1'b1; m4_pulse = 1'b0; w4.len = 0; pos4 = 0;
    end else begin
      if (m1_ready && tx_valid1) begin w1 = build(tx_data1, 1, m1_line); pos1 = 0; end
      if (pos1 < w1.len) begin
        m1_line = w1.ln[pos1]; m1_pulse = w1.pl[pos1]; m1_ready = 1'b0; pos1++;
      end else begin
        m1_ready = 1'b1; m1_pulse = 1'b0;
      end
      if (m4_ready && tx_valid4) begin w4 = build(tx_data4, 4, m4_line); pos4 = 0; end
      if (pos4 < w4.len) begin
        m4_line = w4.ln[pos4]; m4_pulse = w4.pl[pos4]; m4_ready = 1'b0; pos4++;
      end else begin
        m4_ready = 1'b1; m4_pulse = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({line1, ready1, busy1, pulse1} !== {m1_line, m1_ready, ~m1_ready, m1_pulse}) begin
      errors++;
      $display("FAIL model_cpb1 t=%0t: line/ready/busy/pulse got %b%b%b%b required %b%b%b%b",
               $time, line1, ready1, busy1, pulse1, m1_line, m1_ready, ~m1_ready, m1_pulse);
    end
    checks++;
    if ({line4, ready4, busy4, pulse4} !== {m4_line, m4_ready, ~m4_ready, m4_pulse}) begin
      errors++;
      $display("FAIL model_cpb4 t=%0t: line/ready/busy/pulse got %b%b%b%b required %b%b%b%b",
               $time, line4, ready4, busy4, pulse4, m4_line, m4_ready, ~m4_ready, m4_pulse);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    tx_valid1 = 1'b0; tx_valid4 = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offers a word to the CPB=1 instance and records n samples starting after the accept edge.
  task automatic run1(input logic [7:0] d, input bit b2b, input int n,
                      output logic [63:0] ln, output logic [63:0] rd, output logic [63:0] pl);
    bit prev;
    prev = 1'b0; ln = '0; rd = '0; pl = '0;
    @(negedge clk);
    tx_data1 = d; tx_valid1 = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ln[i] = line1; rd[i] = ready1; pl[i] = pulse1;
      if (!b2b && i == 0) tx_valid1 = 1'b0;
      if (b2b && i == 0) tx_data1 = 8'h80;
      if (b2b && prev && !ready1) tx_valid1 = 1'b0;
      prev = ready1;
    end
  endtask

  function automatic logic [7:0] rand_word();
    case ($urandom_range(0, 2))
      0: return 8'($urandom);
      1: return 8'($urandom & $urandom & $urandom);
      default: begin
        logic [31:0] pick;
        pick = 32'h00FF_4001;
        return pick[8*$urandom_range(0, 3) +: 8];
      end
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ln, rd, pl, exp_ln;
    logic [7:0]  lv;
    bit          p1, p4;
    repeat (2) @(negedge clk);
    chk("reset_state", {60'h0, line1, ready1, busy1, pulse1}, 64'b1100);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run1(8'hFF, 1'b0, 9, ln, rd, pl);
    chk("ff_line", ln, 64'b110101010);
    chk("ff_ready", rd, 64'b100000000);
    chk("ff_pulse", pl, 64'h0);

`ifdef NRZI_BIT_STUFF_EN
    run1(8'h00, 1'b0, 10, ln, rd, pl);
    chk("zero_line", ln, 64'b0000111111);
    chk("zero_ready", rd, 64'b1000000000);
    chk("zero_pulse", pl, 64'b0001000000);
`else
    run1(8'h00, 1'b0, 9, ln, rd, pl);
    chk("zero_line", ln, 64'b111111111);
    chk("zero_ready", rd, 64'b100000000);
    chk("zero_pulse", pl, 64'h0);
`endif

    do_reset();
`ifdef NRZI_BIT_STUFF_EN
    run1(8'h01, 1'b1, 20, ln, rd, pl);
    chk("b2b_line", ln, 64'b1100_1111_1111_1000_0000);
    chk("b2b_ready", rd, 64'b1000_0000_0010_0000_0000);
    chk("b2b_pulse", pl, 64'b0001_0000_0000_1000_0000);
`else
    run1(8'h01, 1'b1, 18, ln, rd, pl);
    chk("b2b_line", ln, 64'b11_0000_0000_0000_0000);
    chk("b2b_ready", rd, 64'b10_0000_0001_0000_0000);
    chk("b2b_pulse", pl, 64'h0);
`endif

    // 0xA5 at four clocks per bit: levels 0,0,1,1,1,0,0,1 then idle at 1.
    lv = 8'b1001_1100;
    exp_ln = '0;
    for (int s = 0; s < 33; s++) exp_ln[s] = (s < 32) ? lv[s / 4] : 1'b1;
    ln = '0; rd = '0;
    @(negedge clk);
    tx_data4 = 8'hA5; tx_valid4 = 1'b1;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      ln[i] = line4; rd[i] = ready4;
      if (i == 0) tx_valid4 = 1'b0;
    end
    chk("a5_line", ln, exp_ln);
    chk("a5_ready", rd, {31'h0, 1'b1, 32'h0});

    p1 = ready1; p4 = ready4;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (tx_valid1 && p1) tx_valid1 = 1'b0;
      if (!tx_valid1 && $urandom_range(0, 2) == 0) begin tx_valid1 = 1'b1; tx_data1 = rand_word(); end
      if (tx_valid4 && p4) tx_valid4 = 1'b0;
      if (!tx_valid4 && $urandom_range(0, 2) == 0) begin tx_valid4 = 1'b1; tx_data4 = rand_word(); end
      p1 = ready1; p4 = ready4;
    end

    // Mid-word asynchronous reset, checked between clock edges.
    @(negedge clk);
    tx_data1 = 8'h5A; tx_valid1 = 1'b1; tx_data4 = 8'h3C; tx_valid4 = 1'b1;
    for (int k = 0; k < 60 && !(busy1 && busy4); k++) @(negedge clk);
    chk("busy_before_reset", {62'h0, busy1, busy4}, 64'b11);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_cpb1", {60'h0, line1, ready1, busy1, pulse1}, 64'b1100);
    chk("async_reset_cpb4", {60'h0, line4, ready4, busy4, pulse4}, 64'b1100);
    tx_valid1 = 1'b0; tx_valid4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
